// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side MEM-stage access controller.
package dmem_pkg;

    // Access size encodings as seen on req_size / data_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request FSM: nothing latched, or one access held on the sram-like bus.
    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    // Per-transaction bookkeeping carried from address phase to data phase.
    // The caller tag travels beside this struct because its width is a
    // module parameter.
    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
        logic       killed;
    } q_entry_t;

    // Encoding 3 is treated as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    // Expects a normalised size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it could occupy.
    function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_inflight_q.sv
// In-order queue of accesses whose address phase completed and whose data
// phase is still pending. A broadcast kill marks every held entry so its
// eventual data_ok retires silently.
module dmem_inflight_q
    import dmem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  q_entry_t                   push_entry,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    input  logic                       kill_all,
    output q_entry_t                   head_entry,
    output logic [TAG_W-1:0]           head_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    q_entry_t         mem     [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage: broadcast kill first, so a same-cycle push keeps its own killed bit.
    // NOTE: storage is left unreset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (kill_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].killed <= 1'b1;
            end
        end
        if (push) begin
            mem[wr_ptr]     <= push_entry;
            tag_mem[wr_ptr] <= push_tag;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry = mem[rd_ptr];
    assign head_tag   = tag_mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data access controller: one request register driving an
// sram-like bus, an in-order in-flight queue, alignment exceptions, store
// lane placement, load extraction and a pipeline cancel.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          TAG_W           = 4,
    parameter logic [31:0] ADDR_MASK       = 32'h1fff_ffff,
    parameter bit          STORE_RESP      = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             cancel,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic [31:0]      data_rdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             ex_valid,
    output logic             ex_ades,
    output logic [31:0]      ex_badvaddr,
    output logic [TAG_W-1:0] ex_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

    state_t           state, state_nxt;
    logic [1:0]       r_off;
    logic             r_uns;
    logic             r_killed;
    logic [TAG_W-1:0] r_tag;
    logic             ex_pend;

    logic [1:0]       req_size_n;
    logic             req_misaligned;
    logic [CNT_W:0]   slots_used;
    logic             addr_acc, accept, load_req, take_ex;

    q_entry_t         push_entry, head_entry;
    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] q_count;
    logic             q_empty, q_full, q_pop;

    assign req_size_n     = norm_size(req_size);
    assign req_misaligned = misaligned(req_size_n, req_addr[1:0]);
    // The held request counts against the outstanding budget until it is pushed.
    assign slots_used     = {1'b0, q_count} + {{CNT_W{1'b0}}, (state == ST_REQ)};

    // Request FSM next state plus the handshake decisions it depends on.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        data_req  = 1'b0;
        addr_acc  = 1'b0;
        req_ready = 1'b0;
        accept    = 1'b0;
        load_req  = 1'b0;
        take_ex   = 1'b0;
        // While the queue is full the held access is not offered, so addr_ok cannot land.
        data_req  = (state == ST_REQ) && !q_full;
        addr_acc  = data_req && data_addr_ok;
        req_ready = ((state == ST_IDLE) || addr_acc) && (slots_used < MAX_C) && !cancel;
        accept    = req_valid && req_ready;
        load_req  = accept && !req_misaligned;
        take_ex   = accept && req_misaligned;
        case (state)
            ST_IDLE: if (load_req) state_nxt = ST_REQ;
            ST_REQ:  if (addr_acc) state_nxt = load_req ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Request register: bus fields stay frozen from accept until addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_wr    <= 1'b0;
            data_size  <= SZ_BYTE;
            data_addr  <= '0;
            data_wdata <= '0;
            r_off      <= '0;
            r_uns      <= 1'b0;
            r_tag      <= '0;
            r_killed   <= 1'b0;
        end else if (load_req) begin
            data_wr    <= req_wr;
            data_size  <= req_size_n;
            data_addr  <= req_addr & ADDR_MASK;
            data_wdata <= place_wdata(req_size_n, req_wdata);
            r_off      <= req_addr[1:0];
            r_uns      <= req_unsigned;
            r_tag      <= req_tag;
            r_killed   <= 1'b0;
        end else if (state == ST_REQ && cancel) begin
            // A cancelled access cannot be retracted from the bus; remember to drop its data.
            r_killed   <= 1'b1;
        end
    end

    // Alignment exception register: pulses the cycle after a misaligned accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_pend     <= 1'b0;
            ex_ades     <= 1'b0;
            ex_badvaddr <= '0;
            ex_tag      <= '0;
        end else begin
            ex_pend <= take_ex;
            if (take_ex) begin
                ex_ades     <= req_wr;
                ex_badvaddr <= req_addr;
                ex_tag      <= req_tag;
            end
        end
    end

    // Queue entry for the access whose address phase completes this cycle.
    always_comb begin
        push_entry        = '0;
        push_entry.wr     = data_wr;
        push_entry.size   = data_size;
        push_entry.off    = r_off;
        push_entry.uns    = r_uns;
        push_entry.killed = r_killed || cancel;
    end

    // data_ok with nothing in flight is a bus protocol violation; it is ignored.
    assign q_pop = data_data_ok && !q_empty;

    dmem_inflight_q #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_q (
        .clk        (clk),
        .resetn     (resetn),
        .push       (addr_acc),
        .push_entry (push_entry),
        .push_tag   (r_tag),
        .pop        (q_pop),
        .kill_all   (cancel),
        .head_entry (head_entry),
        .head_tag   (head_tag),
        .count      (q_count),
        .empty      (q_empty),
        .full       (q_full)
    );

    assign resp_valid  = q_pop && !head_entry.killed && !cancel && (!head_entry.wr || STORE_RESP);
    assign resp_rdata  = (resp_valid && !head_entry.wr)
                       ? extract_load(data_rdata, head_entry.size, head_entry.off, head_entry.uns)
                       : 32'h0;
    assign resp_tag    = resp_valid ? head_tag : '0;
    assign ex_valid    = ex_pend && !cancel;
    assign busy        = (state != ST_IDLE) || !q_empty;

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
                                          !(data_data_ok && q_empty));

endmodule
